// File: rtl/seq_detect_param_if.sv
// Serial pattern detector bus: sample controls and pattern in, match/count/fill out.
interface seq_detect_param_if #(
    parameter int unsigned W     = 3,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned FILL_W = $clog2(W + 1);

    logic              en;
    logic              in;
    logic [W-1:0]      pattern;
    logic              overlap;
    logic              clear;
    logic              match;
    logic [CNT_W-1:0]  count;
    logic [FILL_W-1:0] fill;

    modport master (
        output en, in, pattern, overlap, clear,
        input  match, count, fill
    );

    modport slave (
        input  en, in, pattern, overlap, clear,
        output match, count, fill
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with overlap control and a saturating
// match counter. The last W sampled bits are compared against a runtime pattern.
module seq_detect_param #(
    parameter int unsigned W     = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              areset_n,
    seq_detect_param_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(W);

    logic [W-1:0]      hist;
    logic [W-1:0]      h_next;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] f_next;
    logic [CNT_W-1:0]  count_q;
    logic              match_q;
    logic              hit;

    // Next history, saturating fill level and hit decision for the current bit
    always_comb begin
        h_next = {hist[W-2:0], bus.in};
        f_next = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        hit    = (f_next == FULL) && (h_next == bus.pattern);
    end

    // Sequential state: clear beats enable; a non-overlapping hit restarts the fill
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            hist    <= '0;
            fill_q  <= '0;
            count_q <= '0;
            match_q <= 1'b0;
        end else if (bus.clear) begin
            hist    <= '0;
            fill_q  <= '0;
            count_q <= '0;
            match_q <= 1'b0;
        end else if (!bus.en) begin
            match_q <= 1'b0;
        end else begin
            hist    <= h_next;
            match_q <= hit;
            if (hit && (count_q != '1))
                count_q <= count_q + 1'b1;
            fill_q  <= (hit && !bus.overlap) ? '0 : f_next;
        end
    end

    assign bus.match = match_q;
    assign bus.count = count_q;
    assign bus.fill  = fill_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a W=3/CNT_W=8 instance for the main
// behaviour and a W=2/CNT_W=2 instance for counter saturation.
module tb_seq_detect_param;
    logic clk;
    logic areset_n;
    int unsigned errors;
    int unsigned checks;

    seq_detect_param_if #(.W(3), .CNT_W(8)) a_if ();
    seq_detect_param_if #(.W(2), .CNT_W(2)) b_if ();

    seq_detect_param #(.W(3), .CNT_W(8)) dut_a (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (a_if.slave)
    );

    seq_detect_param #(.W(2), .CNT_W(2)) dut_b (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and tally the result
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge on instance A; outputs are stable 1 time unit later
    task automatic step_a(input logic b, input logic e = 1'b1, input logic c = 1'b0);
        a_if.in    = b;
        a_if.en    = e;
        a_if.clear = c;
        @(posedge clk);
        #1;
        a_if.en    = 1'b0;
        a_if.clear = 1'b0;
    endtask

    task automatic step_b(input logic b, input logic e = 1'b1, input logic c = 1'b0);
        b_if.in    = b;
        b_if.en    = e;
        b_if.clear = c;
        @(posedge clk);
        #1;
        b_if.en    = 1'b0;
        b_if.clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] bits5;
        logic [4:0] exp_m5;
        logic [4:0] exp_f5;
        logic [5:0] exp_m6;
        errors = 0;
        checks = 0;

        a_if.en = 1'b0; a_if.in = 1'b0; a_if.clear = 1'b0;
        a_if.pattern = 3'b101; a_if.overlap = 1'b1;
        b_if.en = 1'b0; b_if.in = 1'b0; b_if.clear = 1'b0;
        b_if.pattern = 2'b11; b_if.overlap = 1'b1;

        areset_n = 1'b1;
        #1 areset_n = 1'b0;
        #1;
        check("rst_match", 32'(a_if.match), 0);
        check("rst_count", 32'(a_if.count), 0);
        check("rst_fill",  32'(a_if.fill),  0);
        @(negedge clk);
        areset_n = 1'b1;

        // Overlapping 10101 with pattern 101: hits on bits 3 and 5
        bits5  = 5'b10101;
        exp_m5 = 5'b00101;
        for (int i = 4; i >= 0; i--) begin
            step_a(bits5[i]);
            check($sformatf("ov_match%0d", 4 - i), 32'(a_if.match), 32'(exp_m5[i]));
        end
        check("ov_count", 32'(a_if.count), 2);
        check("ov_fill",  32'(a_if.fill),  3);

        step_a(1'b0, 1'b0, 1'b1);
        check("clr_count", 32'(a_if.count), 0);
        check("clr_fill",  32'(a_if.fill),  0);

        // Non-overlapping: one hit, fill restarts after it
        a_if.overlap = 1'b0;
        exp_m5 = 5'b00100;
        exp_f5 = 5'b00000;
        for (int i = 4; i >= 0; i--) begin
            step_a(bits5[i]);
            check($sformatf("nov_match%0d", 4 - i), 32'(a_if.match), 32'(exp_m5[i]));
        end
        check("nov_count", 32'(a_if.count), 1);
        check("nov_fill",  32'(a_if.fill),  2);
        step_a(1'b0, 1'b0, 1'b1);

        // Pattern 111 on a run of ones: four consecutive hits
        a_if.overlap = 1'b1;
        a_if.pattern = 3'b111;
        exp_m6 = 6'b001111;
        for (int i = 5; i >= 0; i--) begin
            step_a(1'b1);
            check($sformatf("run_match%0d", 5 - i), 32'(a_if.match), 32'(exp_m6[i]));
        end
        check("run_count", 32'(a_if.count), 4);
        step_a(1'b0, 1'b0, 1'b1);

        // Enable gaps do not shift history
        a_if.pattern = 3'b101;
        step_a(1'b1);
        step_a(1'b0);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, 1'b0);
            check($sformatf("gap_match%0d", i), 32'(a_if.match), 0);
            check($sformatf("gap_fill%0d", i),  32'(a_if.fill),  2);
        end
        step_a(1'b1);
        check("gap_hit",   32'(a_if.match), 1);
        check("gap_count", 32'(a_if.count), 1);

        // clear together with en: clear wins and the bit is lost
        step_a(1'b1, 1'b1, 1'b1);
        check("clren_fill",  32'(a_if.fill),  0);
        check("clren_count", 32'(a_if.count), 0);
        check("clren_match", 32'(a_if.match), 0);

        // Saturating counter on the W=2, CNT_W=2 instance
        exp_m6 = 6'b011111;
        for (int i = 5; i >= 0; i--) begin
            int unsigned n;
            n = 6 - i - 1;
            step_b(1'b1);
            check($sformatf("sat_match%0d", 5 - i), 32'(b_if.match), 32'(exp_m6[i]));
            check($sformatf("sat_count%0d", 5 - i), 32'(b_if.count), (n > 3) ? 3 : n);
        end
        step_b(1'b0, 1'b0, 1'b1);
        check("satclr_count", 32'(b_if.count), 0);
        check("satclr_fill",  32'(b_if.fill),  0);
        check("satclr_match", 32'(b_if.match), 0);

        // Asynchronous reset mid-cycle loses all progress
        step_a(1'b1);
        step_a(1'b0);
        step_a(1'b1);
        check("pre_hit", 32'(a_if.match), 1);
        step_a(1'b1);
        step_a(1'b0);
        check("pre_count", 32'(a_if.count), 1);
        check("pre_fill",  32'(a_if.fill),  3);
        #2 areset_n = 1'b0;
        #1;
        check("arst_count", 32'(a_if.count), 0);
        check("arst_fill",  32'(a_if.fill),  0);
        check("arst_match", 32'(a_if.match), 0);
        @(negedge clk);
        areset_n = 1'b1;
        step_a(1'b1);
        check("post1_match", 32'(a_if.match), 0);
        check("post1_fill",  32'(a_if.fill),  1);
        step_a(1'b0);
        check("post2_match", 32'(a_if.match), 0);
        step_a(1'b1);
        check("post3_match", 32'(a_if.match), 1);
        check("post3_count", 32'(a_if.count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
